// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings used by the bus master and the slaves on the
// same fabric: transfer types, burst types, sizes, responses and direction.
package ahb_lite_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST burst types
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // HSIZE transfer sizes
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // HRESP responses
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Transfer direction as carried on HWRITE
    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    // Protection attributes: non-cacheable, non-bufferable, privileged, data
    localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

    // Highest 1 KB offset at which a 4-beat word burst still fits the page
    localparam logic [9:0] INCR4_LAST_START = 10'h3F0;

    // True when a 4-beat word burst starting at this page offset would
    // cross a 1 KB address boundary
    function automatic logic incr4_crosses_1kb(input logic [9:0] offset);
        return (offset > INCR4_LAST_START);
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite bus master front end. Converts word read/write commands from an
// internal client into SINGLE or INCR4 transfers, with pipelined address and
// data phases, wait states, BUSY insertion for late write data and the
// two-cycle ERROR response.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    // client command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_burst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              done_err,
    // AHB-Lite master side
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [1:0]        HTRANS,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,   // waiting for a command
        ST_ADDR = 2'b01,   // address phases, overlapping previous data phase
        ST_LAST = 2'b10,   // final data phase only
        ST_ERR2 = 2'b11    // second cycle of an ERROR response
    } state_t;

    // registered state
    state_t            state_r,    state_nx_s;
    logic [1:0]        htrans_r,   htrans_nx_s;
    logic [ADDR_W-1:0] haddr_r,    haddr_nx_s;
    logic              hwrite_r,   hwrite_nx_s;
    logic [2:0]        hburst_r,   hburst_nx_s;
    logic [DATA_W-1:0] hwdata_r,   hwdata_nx_s;
    logic [1:0]        beat_r,     beat_nx_s;
    logic [1:0]        last_r,     last_nx_s;
    logic              dphase_r,   dphase_nx_s;
    logic              done_r,     done_nx_s;
    logic              done_err_r, done_err_nx_s;

    // combinational helpers
    logic [1:0] htrans_s;
    logic       cmd_ready_s;
    logic       accept_s;
    logic       reject_s;
    logic       aphase_done_s;
    logic       err_first_s;
    logic       unused_addr_lsb_s;

    // Address bits [1:0] are forced to zero for word transfers
    assign unused_addr_lsb_s = ^cmd_addr[1:0];

    // A pending SEQ on a write burst is shown as BUSY until the client has
    // the next beat ready; address and control already hold that beat.
    assign htrans_s = ((htrans_r == HTRANS_SEQ) && (hwrite_r == DIR_WRITE) && !wdata_valid)
                      ? HTRANS_BUSY : htrans_r;

    // Idle and not still signalling the previous completion
    assign cmd_ready_s   = (state_r == ST_IDLE) && !done_r;
    assign accept_s      = cmd_ready_s && cmd_valid && (!cmd_write || wdata_valid);
    assign reject_s      = accept_s && cmd_burst && incr4_crosses_1kb(cmd_addr[9:0]);
    assign aphase_done_s = (state_r == ST_ADDR) && HREADY &&
                           ((htrans_s == HTRANS_NONSEQ) || (htrans_s == HTRANS_SEQ));
    assign err_first_s   = dphase_r && (HRESP == HRESP_ERROR) && !HREADY &&
                           ((state_r == ST_ADDR) || (state_r == ST_LAST));

    // client-facing outputs
    assign cmd_ready   = cmd_ready_s;
    assign wdata_ready = aphase_done_s && (hwrite_r == DIR_WRITE);
    assign rdata       = HRDATA;
    assign rdata_valid = dphase_r && (hwrite_r == DIR_READ) && HREADY && (HRESP == HRESP_OKAY);
    assign done        = done_r;
    assign done_err    = done_err_r;

    // bus-facing outputs
    assign HADDR     = haddr_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = hburst_r;
    assign HPROT     = HPROT_PRIV_DATA;
    assign HTRANS    = htrans_s;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_r;

    // Next-state and next-register values for the transfer FSM
    always_comb begin
        state_nx_s    = state_r;
        htrans_nx_s   = htrans_r;
        haddr_nx_s    = haddr_r;
        hwrite_nx_s   = hwrite_r;
        hburst_nx_s   = hburst_r;
        hwdata_nx_s   = hwdata_r;
        beat_nx_s     = beat_r;
        last_nx_s     = last_r;
        dphase_nx_s   = dphase_r;
        done_nx_s     = 1'b0;
        done_err_nx_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (reject_s) begin
                    // burst would cross a 1 KB page: complete with error, no bus activity
                    done_nx_s     = 1'b1;
                    done_err_nx_s = 1'b1;
                end else if (accept_s) begin
                    state_nx_s  = ST_ADDR;
                    htrans_nx_s = HTRANS_NONSEQ;
                    haddr_nx_s  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    hwrite_nx_s = cmd_write;
                    hburst_nx_s = cmd_burst ? HBURST_INCR4 : HBURST_SINGLE;
                    beat_nx_s   = 2'd0;
                    last_nx_s   = cmd_burst ? 2'd3 : 2'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (err_first_s) begin
                    // abandon the outstanding address and remaining beats
                    state_nx_s    = ST_ERR2;
                    htrans_nx_s   = HTRANS_IDLE;
                    dphase_nx_s   = 1'b0;
                    done_nx_s     = 1'b1;
                    done_err_nx_s = 1'b1;
                end else if (HREADY) begin
                    dphase_nx_s = aphase_done_s;
                    if (aphase_done_s) begin
                        if (hwrite_r == DIR_WRITE) begin
                            hwdata_nx_s = wdata;
                        end else begin
                            hwdata_nx_s = hwdata_r;
                        end
                        if (beat_r == last_r) begin
                            state_nx_s  = ST_LAST;
                            htrans_nx_s = HTRANS_IDLE;
                        end else begin
                            htrans_nx_s = HTRANS_SEQ;
                            haddr_nx_s  = haddr_r + ADDR_W'(4);
                            beat_nx_s   = beat_r + 2'd1;
                        end
                    end else begin
                        // BUSY cycle: nothing advances
                        htrans_nx_s = htrans_r;
                    end
                end else begin
                    // wait state: hold address phase and data phase
                    state_nx_s = ST_ADDR;
                end
            end

            ST_LAST: begin
                if (err_first_s) begin
                    state_nx_s    = ST_ERR2;
                    htrans_nx_s   = HTRANS_IDLE;
                    dphase_nx_s   = 1'b0;
                    done_nx_s     = 1'b1;
                    done_err_nx_s = 1'b1;
                end else if (HREADY) begin
                    state_nx_s    = ST_IDLE;
                    dphase_nx_s   = 1'b0;
                    done_nx_s     = 1'b1;
                    done_err_nx_s = HRESP;
                end else begin
                    state_nx_s = ST_LAST;
                end
            end

            ST_ERR2: begin
                if (HREADY) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ERR2;
                end
            end

            default: begin
                state_nx_s  = ST_IDLE;
                htrans_nx_s = HTRANS_IDLE;
                dphase_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            htrans_r   <= HTRANS_IDLE;
            haddr_r    <= '0;
            hwrite_r   <= DIR_READ;
            hburst_r   <= HBURST_SINGLE;
            hwdata_r   <= '0;
            beat_r     <= 2'd0;
            last_r     <= 2'd0;
            dphase_r   <= 1'b0;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            htrans_r   <= htrans_nx_s;
            haddr_r    <= haddr_nx_s;
            hwrite_r   <= hwrite_nx_s;
            hburst_r   <= hburst_nx_s;
            hwdata_r   <= hwdata_nx_s;
            beat_r     <= beat_nx_s;
            last_r     <= last_nx_s;
            dphase_r   <= dphase_nx_s;
            done_r     <= done_nx_s;
            done_err_r <= done_err_nx_s;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: single write, waited INCR4 read,
// INCR4 write with a BUSY cycle, ERROR on a read burst, 1 KB rejection,
// a page-end SINGLE and reset in the middle of a burst.
module tb_ahb_lite_master;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_burst;
    logic [31:0] cmd_addr;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid, done, done_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .done_err(done_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " HTRANS"}, {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        chk({tag, " HADDR"}, HADDR, 32'h0000_0000);
        chk({tag, " HWRITE"}, {31'd0, HWRITE}, 32'd0);
        chk({tag, " HSIZE"}, {29'd0, HSIZE}, 32'd2);
        chk({tag, " HBURST"}, {29'd0, HBURST}, 32'd0);
        chk({tag, " HPROT"}, {28'd0, HPROT}, 32'd3);
        chk({tag, " HMASTLOCK"}, {31'd0, HMASTLOCK}, 32'd0);
        chk({tag, " HWDATA"}, HWDATA, 32'h0000_0000);
        chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, " wdata_ready"}, {31'd0, wdata_ready}, 32'd0);
        chk({tag, " rdata_valid"}, {31'd0, rdata_valid}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " done_err"}, {31'd0, done_err}, 32'd0);
    endtask

    // present a command for one cycle; it must be accepted
    task automatic issue(input logic wr, input logic [31:0] addr, input logic burst,
                         input logic [31:0] wd);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_burst   = burst;
        wdata       = wd;
        wdata_valid = wr;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        #1;
        chk("accept cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("accept HTRANS", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        cyc();
        cmd_valid = 1'b0;
    endtask

    // drive one bus cycle of slave response and check the master's outputs
    task automatic step(input string tag, input logic hr, input logic hresp,
                        input logic [31:0] hrd, input logic [1:0] e_tr,
                        input logic [31:0] e_ad, input logic e_wr, input logic e_rv,
                        input logic e_dn, input logic e_er);
        HREADY = hr;
        HRESP  = hresp;
        HRDATA = hrd;
        #1;
        chk({tag, " HTRANS"}, {30'd0, HTRANS}, {30'd0, e_tr});
        if (e_tr != HTRANS_IDLE) chk({tag, " HADDR"}, HADDR, e_ad);
        chk({tag, " wdata_ready"}, {31'd0, wdata_ready}, {31'd0, e_wr});
        chk({tag, " rdata_valid"}, {31'd0, rdata_valid}, {31'd0, e_rv});
        if (e_rv) chk({tag, " rdata"}, rdata, hrd);
        chk({tag, " done"}, {31'd0, done}, {31'd0, e_dn});
        chk({tag, " done_err"}, {31'd0, done_err}, {31'd0, e_er});
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_burst = 1'b0; wdata = 32'd0; wdata_valid = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        cyc(); cyc();
        chk_reset("reset");
        HRESET = 1'b0;
        cyc();

        // single write 0x100 <- 0xDEADBEEF, zero wait states
        issue(1'b1, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF);
        chk("w1 HBURST", {29'd0, HBURST}, {29'd0, HBURST_SINGLE});
        chk("w1 HWRITE", {31'd0, HWRITE}, 32'd1);
        chk("w1 cmd_ready busy", {31'd0, cmd_ready}, 32'd0);
        step("w1 c1", 1'b1, 1'b0, 32'd0, HTRANS_NONSEQ, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        wdata_valid = 1'b0;
        chk("w1 HWDATA", HWDATA, 32'hDEAD_BEEF);
        step("w1 c2", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w1 cmd_ready in done", {31'd0, cmd_ready}, 32'd0);
        step("w1 c3", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("w1 cmd_ready after", {31'd0, cmd_ready}, 32'd1);

        // INCR4 read from 0x200, beat 2 data phase waits two cycles
        issue(1'b0, 32'h0000_0200, 1'b1, 32'd0);
        chk("r4 HBURST", {29'd0, HBURST}, {29'd0, HBURST_INCR4});
        step("r4 c1", 1'b1, 1'b0, 32'h0,         HTRANS_NONSEQ, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r4 c2", 1'b1, 1'b0, 32'h1111_0000, HTRANS_SEQ,    32'h204, 1'b0, 1'b1, 1'b0, 1'b0);
        step("r4 c3", 1'b0, 1'b0, 32'h0BAD_0BAD, HTRANS_SEQ,    32'h208, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r4 c4", 1'b0, 1'b0, 32'h0BAD_0BAD, HTRANS_SEQ,    32'h208, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r4 c5", 1'b1, 1'b0, 32'h2222_0001, HTRANS_SEQ,    32'h208, 1'b0, 1'b1, 1'b0, 1'b0);
        step("r4 c6", 1'b1, 1'b0, 32'h3333_0002, HTRANS_SEQ,    32'h20C, 1'b0, 1'b1, 1'b0, 1'b0);
        step("r4 c7", 1'b1, 1'b0, 32'h4444_0003, HTRANS_IDLE,   32'h0,   1'b0, 1'b1, 1'b0, 1'b0);
        step("r4 c8", 1'b1, 1'b0, 32'h0,         HTRANS_IDLE,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0);

        // INCR4 write from 0x200, third beat's data late by one cycle
        issue(1'b1, 32'h0000_0200, 1'b1, 32'hA000_0000);
        step("w4 c1", 1'b1, 1'b0, 32'd0, HTRANS_NONSEQ, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        wdata = 32'hA000_0001;
        chk("w4 HWDATA b1", HWDATA, 32'hA000_0000);
        step("w4 c2", 1'b1, 1'b0, 32'd0, HTRANS_SEQ, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
        wdata_valid = 1'b0;
        chk("w4 HWDATA b2", HWDATA, 32'hA000_0001);
        step("w4 c3 busy", 1'b1, 1'b0, 32'd0, HTRANS_BUSY, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0);
        wdata = 32'hA000_0002; wdata_valid = 1'b1;
        step("w4 c4", 1'b1, 1'b0, 32'd0, HTRANS_SEQ, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        wdata = 32'hA000_0003;
        chk("w4 HWDATA b3", HWDATA, 32'hA000_0002);
        step("w4 c5", 1'b1, 1'b0, 32'd0, HTRANS_SEQ, 32'h20C, 1'b1, 1'b0, 1'b0, 1'b0);
        wdata_valid = 1'b0;
        chk("w4 HWDATA b4", HWDATA, 32'hA000_0003);
        step("w4 c6", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("w4 c7", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // INCR4 read from 0x300, ERROR on beat 2
        issue(1'b0, 32'h0000_0300, 1'b1, 32'd0);
        step("re c1", 1'b1, 1'b0, 32'h0,         HTRANS_NONSEQ, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        step("re c2", 1'b1, 1'b0, 32'h5555_0000, HTRANS_SEQ,    32'h304, 1'b0, 1'b1, 1'b0, 1'b0);
        step("re c3", 1'b0, 1'b1, 32'h6666_0001, HTRANS_SEQ,    32'h308, 1'b0, 1'b0, 1'b0, 1'b0);
        step("re c4", 1'b1, 1'b1, 32'h6666_0001, HTRANS_IDLE,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1);
        step("re c5", 1'b1, 1'b0, 32'h0,         HTRANS_IDLE,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
        chk("re cmd_ready after", {31'd0, cmd_ready}, 32'd1);

        // INCR4 at 0x3F4 crosses 1 KB: rejected without bus activity
        issue(1'b0, 32'h0000_03F4, 1'b1, 32'd0);
        chk("kb cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step("kb c1", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("kb c2", 1'b1, 1'b0, 32'd0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("kb cmd_ready after", {31'd0, cmd_ready}, 32'd1);

        // SINGLE read at the end of a page, low address bits dropped
        issue(1'b0, 32'h0000_03FE, 1'b0, 32'd0);
        step("pe c1", 1'b1, 1'b0, 32'h0,         HTRANS_NONSEQ, 32'h3FC, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pe c2", 1'b1, 1'b0, 32'h7777_7777, HTRANS_IDLE,   32'h0,   1'b0, 1'b1, 1'b0, 1'b0);
        step("pe c3", 1'b1, 1'b0, 32'h0,         HTRANS_IDLE,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0);

        // reset during the third beat of an INCR4 read
        issue(1'b0, 32'h0000_0400, 1'b1, 32'd0);
        step("rs c1", 1'b1, 1'b0, 32'h0,         HTRANS_NONSEQ, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rs c2", 1'b1, 1'b0, 32'h8888_0000, HTRANS_SEQ,    32'h404, 1'b0, 1'b1, 1'b0, 1'b0);
        HRESET = 1'b1;
        step("rs c3", 1'b1, 1'b0, 32'h9999_0001, HTRANS_SEQ,    32'h408, 1'b0, 1'b1, 1'b0, 1'b0);
        HRESET = 1'b0;
        chk_reset("midreset");
        step("rs c5", 1'b1, 1'b0, 32'h0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rs cmd_ready after", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
